sd_spi_card_responder: RTL and testbench
========================================

Name: sd_spi_card_responder

Overview:
Card-side counterpart of the team's microSD SPI host: emulates the SPI-mode response path of a microSD card so the host block can be exercised on the bench and in loopback. Oversamples SCLK/CS/MOSI in the CLK50 domain and enforces the ≥74-clock power-up rule. Parses 6-byte command frames and returns an R1 byte after a programmable NCR gap. Tracks the card idle state through CMD0 / CMD55 / ACMD41.

Parameters:
NCR, 1, number of 0xFF filler bytes between the last command byte and R1 (legal 1..8)
INIT_CLKS, 74, SCLK rising edges with CS high required before commands are accepted
BUSY_CNT, 2, number of ACMD41 commands answered 0x01 before the card leaves idle (0 = first ACMD41 returns 0x00)

Ports:
CLK50  input  1  system clock, 50 MHz
RST  input  1  asynchronous reset, active-high
SCLK  input  1  SPI clock from host, mode 0; high and low phases each ≥4 CLK50 cycles (SCLK ≤ CLK50/8)
CS  input  1  chip select from host, active-low
MOSI  input  1  host-to-card data
MISO  output  1  card-to-host data, MSB first
CMD_STB  output  1  one-CLK50 pulse per complete, accepted command frame
CMD_IDX  output  6  index of the last accepted command
CMD_ARG  output  32  argument of the last accepted command
CARD_IDLE  output  1  R1 idle bit currently held by the card
INIT_DONE  output  1  high once INIT_CLKS edges have been counted

Behaviour:
- Reset values: MISO=1, CMD_STB=0, CMD_IDX=0, CMD_ARG=0, CARD_IDLE=1, INIT_DONE=0, APP flag=0, busy counter=BUSY_CNT, state=WAIT_INIT.
- Async RST mid-frame returns everything to the reset values immediately.
- Input capture: SCLK, CS, MOSI each pass through a 2-FF synchroniser. Edges are detected on the synchronised SCLK. MOSI is sampled on the same CLK50 cycle that a rising edge is detected.
- MISO output: updates within 3 CLK50 cycles of the SCLK edge that causes the update.
- WAIT_INIT:
  - Count rising edges while CS=1; counter saturates at INIT_CLKS.
  - INIT_DONE rises on reaching INIT_CLKS and then stays high until RST.
  - Then go to HUNT. Edges with CS=0 do not count and MISO stays 1.
- Byte framing: a 3-bit bit counter clears whenever CS=1. A byte completes on every 8th rising edge with CS=0.
- HUNT:
  - A completed byte with [7:6]=01 becomes command byte 0 → CMD.
  - Any other byte is ignored. MISO=1.
- CMD:
  - Collect 5 more bytes: 32-bit argument MSB first, then CRC7+end bit. CRC7 is not checked.
  - After byte 6:
    - Latch CMD_IDX and CMD_ARG.
    - Pulse CMD_STB for one CLK50 cycle.
    - Compute R1, then go to GAP.
- R1 rules, evaluated in priority order (idle = CARD_IDLE before update):
  1. End bit 0 → R1 = 0x08 | idle; no state change; APP cleared.
  2. CMD0 → CARD_IDLE=1, busy counter=BUSY_CNT, APP=0; R1=0x01.
  3. CMD55 → APP=1; R1=idle.
  4. CMD41 with APP=1 → if busy counter=0, CARD_IDLE=0 and R1=0x00; else decrement the counter and R1=0x01. APP cleared.
  5. Anything else, including CMD41 without APP → R1 = 0x04 | idle; APP cleared.
- GAP: transmit NCR bytes of 0xFF, then go to RESP.
- RESP: transmit R1, then return to HUNT. MOSI bytes received during GAP/RESP are discarded and never start a frame.
- Transmit timing:
  - The TX byte register loads on the rising edge that completes the previous byte, and its MSB drives MISO immediately.
  - It shifts on the falling edges after rising edges 1..7 of the byte.
  - Outside GAP/RESP, MISO=1.
- CS rising while in CMD/GAP/RESP: abort to HUNT, discard the partial frame, MISO=1, no CMD_STB. Idle/APP/busy state is unaffected.
- Simultaneous events: CS rising detected on the same CLK50 cycle as an SCLK edge → CS wins and the edge is ignored.

Test Plan:
- 40 SCLK with CS high, then CS low and send 40 00 00 00 00 95 plus 2 filler bytes → MISO reads FF FF FF; no CMD_STB; INIT_DONE=0.
- 80 SCLK with CS high, then CMD0 40 00 00 00 00 95 plus 2 filler bytes → MISO reads FF then 01; exactly one CMD_STB; CMD_IDX=0; CMD_ARG=0; CARD_IDLE=1.
- BUSY_CNT=2; after CMD0, loop CMD55 (77 00 00 00 00 65) + ACMD41 (69 40 00 00 00 77) → ACMD41 R1 sequence 01, 01, 00; CMD55 R1 01, 01, 01; CARD_IDLE falls after the third ACMD41.
- CMD17 (51 00 00 12 34 FF) while idle → R1=0x05; CMD_ARG=0x00001234. After leaving idle → R1=0x04.
- CMD0 with last byte 0x94 → R1=0x09. Then CS raised after 3 bytes of a CMD0 frame → no CMD_STB, MISO=1; the next full CMD0 returns 01.
- NCR=3 → exactly three 0xFF bytes precede R1. RST pulsed during GAP → MISO=1 immediately; CARD_IDLE=1; INIT_DONE=0.

Source files
------------

// File: rtl/sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// sd_spi_card_responder : SPI-mode microSD card response-path emulator
// Revision 1.0
// ============================================================================
module sd_spi_card_responder #(
  parameter int NCR       = 1,
  parameter int INIT_CLKS = 74,
  parameter int BUSY_CNT  = 2
) (
  input  logic        CLK50,
  input  logic        RST,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        CMD_STB,
  output logic [5:0]  CMD_IDX,
  output logic [31:0] CMD_ARG,
  output logic        CARD_IDLE,
  output logic        INIT_DONE
);

  localparam int IW = (INIT_CLKS < 1) ? 1 : $clog2(INIT_CLKS + 1);
  localparam int BW = (BUSY_CNT < 1) ? 1 : $clog2(BUSY_CNT + 1);

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    HUNT      = 3'd1,
    CMD       = 3'd2,
    GAP       = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t state, state_n;

  logic [1:0]    sclk_sync, cs_sync, mosi_sync;
  logic          sclk_q, cs_q;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sr;
  logic [2:0]    byte_idx;
  logic [5:0]    idx_buf;
  logic [31:0]   arg_buf;
  logic [7:0]    tx_sr;
  logic [7:0]    r1;
  logic [2:0]    gap_cnt;
  logic [IW-1:0] init_cnt;
  logic [BW-1:0] busy;
  logic          app;

  // A CS rise seen together with an SCLK edge suppresses that edge.
  logic       cs_hi, cs_rise, rise, fall, byte_done, init_hit;
  logic [7:0] rx_next;

  assign cs_hi     = cs_sync[1];
  assign cs_rise   = cs_hi & ~cs_q;
  assign rise      = sclk_sync[1] & ~sclk_q & ~cs_rise;
  assign fall      = ~sclk_sync[1] & sclk_q & ~cs_rise;
  assign rx_next   = {rx_sr, mosi_sync[1]};
  assign byte_done = rise & ~cs_hi & (bit_cnt == 3'd7);
  assign init_hit  = (state == WAIT_INIT) & rise & cs_hi &
                     (init_cnt == IW'(INIT_CLKS - 1));

  assign MISO = ((state == GAP) || (state == RESP)) ? tx_sr[7] : 1'b1;

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], SCLK};
      cs_sync   <= {cs_sync[0], CS};
      mosi_sync <= {mosi_sync[0], MOSI};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) state <= WAIT_INIT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_INIT: if (init_hit) state_n = HUNT;
      HUNT:      if (byte_done && rx_next[7:6] == 2'b01) state_n = CMD;
      CMD:       if (byte_done && byte_idx == 3'd5) state_n = GAP;
      GAP:       if (byte_done && gap_cnt == 3'(NCR - 1)) state_n = RESP;
      RESP:      if (byte_done) state_n = HUNT;
      default:   state_n = WAIT_INIT;
    endcase
    if (cs_rise && (state == CMD || state == GAP || state == RESP))
      state_n = HUNT;
  end

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      CMD_STB   <= 1'b0;
      CMD_IDX   <= '0;
      CMD_ARG   <= '0;
      CARD_IDLE <= 1'b1;
      INIT_DONE <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      byte_idx  <= '0;
      idx_buf   <= '0;
      arg_buf   <= '0;
      tx_sr     <= 8'hFF;
      r1        <= 8'hFF;
      gap_cnt   <= '0;
      init_cnt  <= '0;
      busy      <= BW'(BUSY_CNT);
      app       <= 1'b0;
    end else begin
      CMD_STB <= 1'b0;
      if (cs_hi)     bit_cnt <= '0;
      else if (rise) bit_cnt <= bit_cnt + 3'd1;
      if (rise && !cs_hi) rx_sr <= rx_next[6:0];

      if (state == WAIT_INIT && rise && cs_hi && init_cnt != IW'(INIT_CLKS))
        init_cnt <= init_cnt + IW'(1);
      if (init_hit) INIT_DONE <= 1'b1;

      // Falling edges after bits 1..7 shift; after bit 8 a new byte is already loaded.
      if (fall && bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b1};

      if (byte_done) begin
        unique case (state)
          HUNT: begin
            idx_buf  <= rx_next[5:0];
            byte_idx <= 3'd1;
          end
          CMD: begin
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx != 3'd5) begin
              arg_buf <= {arg_buf[23:0], rx_next};
            end else begin
              CMD_STB <= 1'b1;
              CMD_IDX <= idx_buf;
              CMD_ARG <= arg_buf;
              tx_sr   <= 8'hFF;
              gap_cnt <= '0;
              if (!rx_next[0]) begin
                r1  <= {4'b0000, 1'b1, 2'b00, CARD_IDLE};
                app <= 1'b0;
              end else if (idx_buf == 6'd0) begin
                CARD_IDLE <= 1'b1;
                busy      <= BW'(BUSY_CNT);
                app       <= 1'b0;
                r1        <= 8'h01;
              end else if (idx_buf == 6'd55) begin
                app <= 1'b1;
                r1  <= {7'b0, CARD_IDLE};
              end else if (idx_buf == 6'd41 && app) begin
                app <= 1'b0;
                if (busy == '0) begin
                  CARD_IDLE <= 1'b0;
                  r1        <= 8'h00;
                end else begin
                  busy <= busy - BW'(1);
                  r1   <= 8'h01;
                end
              end else begin
                r1  <= {5'b0, 1'b1, 1'b0, CARD_IDLE};
                app <= 1'b0;
              end
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + 3'd1;
            tx_sr   <= (gap_cnt == 3'(NCR - 1)) ? r1 : 8'hFF;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_card_responder.sv
`default_nettype none
// Bench for sd_spi_card_responder: drives two instances (NCR=1 and NCR=3) from one
// SPI host model; a single monitor scores MISO bytes, command strobes and status checks.
module tb_sd_spi_card_responder;

  logic CLK50 = 1'b0;
  logic RST, SCLK, CS, MOSI;
  logic MISO, CMD_STB, CARD_IDLE, INIT_DONE;
  logic [5:0] CMD_IDX;
  logic [31:0] CMD_ARG;
  logic MISO3, CMD_STB3, CARD_IDLE3, INIT_DONE3;
  logic [5:0] CMD_IDX3;
  logic [31:0] CMD_ARG3;

  always #10 CLK50 = ~CLK50;

  sd_spi_card_responder dut (
    .CLK50(CLK50), .RST(RST), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
    .MISO(MISO), .CMD_STB(CMD_STB), .CMD_IDX(CMD_IDX), .CMD_ARG(CMD_ARG),
    .CARD_IDLE(CARD_IDLE), .INIT_DONE(INIT_DONE)
  );

  sd_spi_card_responder #(.NCR(3)) dut3 (
    .CLK50(CLK50), .RST(RST), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
    .MISO(MISO3), .CMD_STB(CMD_STB3), .CMD_IDX(CMD_IDX3), .CMD_ARG(CMD_ARG3),
    .CARD_IDLE(CARD_IDLE3), .INIT_DONE(INIT_DONE3)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$], exp3_q[$];
  logic [37:0] stb_q[$], stb3_q[$];
  string       chk_name[$];
  logic [31:0] chk_got[$], chk_exp[$];

  logic        sclk_prev = 1'b0;
  int          bit_n = 0;
  logic [7:0]  sh = 8'h00, sh3 = 8'h00, mon_e;
  logic [37:0] mon_s;
  string       mon_n;
  logic [31:0] mon_g, mon_x;

  // Monitor: every comparison in the bench happens here.
  always @(negedge CLK50) begin
    if (CS) begin
      bit_n = 0;
    end else if (SCLK && !sclk_prev) begin
      sh  = {sh[6:0], MISO};
      sh3 = {sh3[6:0], MISO3};
      bit_n++;
      if (bit_n == 8) begin
        bit_n = 0;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL miso_byte_ncr1: got %02h, none expected", sh);
        end else begin
          mon_e = exp_q.pop_front();
          if (sh !== mon_e) begin
            fails++; $display("FAIL miso_byte_ncr1: got %02h, expected %02h", sh, mon_e);
          end
        end
        tests++;
        if (exp3_q.size() == 0) begin
          fails++; $display("FAIL miso_byte_ncr3: got %02h, none expected", sh3);
        end else begin
          mon_e = exp3_q.pop_front();
          if (sh3 !== mon_e) begin
            fails++; $display("FAIL miso_byte_ncr3: got %02h, expected %02h", sh3, mon_e);
          end
        end
      end
    end
    sclk_prev = SCLK;

    if (CMD_STB === 1'b1) begin
      tests++;
      if (stb_q.size() == 0) begin
        fails++; $display("FAIL cmd_stb_ncr1: unexpected strobe idx=%0d arg=%08h", CMD_IDX, CMD_ARG);
      end else begin
        mon_s = stb_q.pop_front();
        if ({CMD_IDX, CMD_ARG} !== mon_s) begin
          fails++; $display("FAIL cmd_ncr1: got idx=%0d arg=%08h, expected idx=%0d arg=%08h",
                            CMD_IDX, CMD_ARG, mon_s[37:32], mon_s[31:0]);
        end
      end
    end
    if (CMD_STB3 === 1'b1) begin
      tests++;
      if (stb3_q.size() == 0) begin
        fails++; $display("FAIL cmd_stb_ncr3: unexpected strobe idx=%0d arg=%08h", CMD_IDX3, CMD_ARG3);
      end else begin
        mon_s = stb3_q.pop_front();
        if ({CMD_IDX3, CMD_ARG3} !== mon_s) begin
          fails++; $display("FAIL cmd_ncr3: got idx=%0d arg=%08h, expected idx=%0d arg=%08h",
                            CMD_IDX3, CMD_ARG3, mon_s[37:32], mon_s[31:0]);
        end
      end
    end

    while (chk_name.size() > 0) begin
      mon_n = chk_name.pop_front();
      mon_g = chk_got.pop_front();
      mon_x = chk_exp.pop_front();
      tests++;
      if (mon_g !== mon_x) begin
        fails++; $display("FAIL %s: got %0h, expected %0h", mon_n, mon_g, mon_x);
      end
    end
  end

  task automatic push_chk(input string n, input logic [31:0] g, input logic [31:0] e);
    chk_name.push_back(n);
    chk_got.push_back(g);
    chk_exp.push_back(e);
  endtask

  task automatic sclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      #100 SCLK = 1'b1;
      #100 SCLK = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      MOSI = b[i];
      #100 SCLK = 1'b1;
      #100 SCLK = 1'b0;
    end
  endtask

  // One 6-byte frame plus four fillers; stb=0 when the card must ignore it.
  task automatic send_cmd(input logic [7:0] c0, input logic [31:0] arg,
                          input logic [7:0] crc, input bit stb, input logic [7:0] r1);
    logic [7:0] fr [10];
    fr = '{c0, arg[31:24], arg[23:16], arg[15:8], arg[7:0], crc,
           8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(8'hFF);
      exp3_q.push_back(8'hFF);
    end
    exp_q.push_back(stb ? r1 : 8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp3_q.push_back(8'hFF);
    exp3_q.push_back(8'hFF);
    exp3_q.push_back(stb ? r1 : 8'hFF);
    if (stb) begin
      stb_q.push_back({c0[5:0], arg});
      stb3_q.push_back({c0[5:0], arg});
    end
    #100 CS = 1'b0;
    for (int i = 0; i < 10; i++) xfer(fr[i]);
    #100 CS = 1'b1;
    MOSI = 1'b1;
    #200;
  endtask

  initial begin
    RST = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b1;
    #105 RST = 1'b0;
    #100;
    push_chk("rst_miso", MISO, 1);
    push_chk("rst_cmd_stb", CMD_STB, 0);
    push_chk("rst_cmd_idx", CMD_IDX, 0);
    push_chk("rst_cmd_arg", CMD_ARG, 0);
    push_chk("rst_card_idle", CARD_IDLE, 1);
    push_chk("rst_init_done", INIT_DONE, 0);

    // Too few init clocks: the frame is ignored.
    sclk_pulses(40);
    push_chk("init_done_after_40", INIT_DONE, 0);
    send_cmd(8'h40, 32'h0, 8'h95, 1'b0, 8'h00);
    push_chk("init_done_after_early_cmd", INIT_DONE, 0);

    sclk_pulses(80);
    push_chk("init_done_after_120", INIT_DONE, 1);
    push_chk("init_done_ncr3", INIT_DONE3, 1);

    send_cmd(8'h40, 32'h0, 8'h95, 1'b1, 8'h01);
    push_chk("idle_after_cmd0", CARD_IDLE, 1);
    send_cmd(8'h51, 32'h0000_1234, 8'hFF, 1'b1, 8'h05);
    send_cmd(8'h40, 32'h0, 8'h94, 1'b1, 8'h09);

    // Aborted CMD0 after three bytes.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hFF);
      exp3_q.push_back(8'hFF);
    end
    #100 CS = 1'b0;
    xfer(8'h40); xfer(8'h00); xfer(8'h00);
    #100 CS = 1'b1;
    MOSI = 1'b1;
    #300;
    push_chk("miso_after_abort", MISO, 1);
    push_chk("miso_after_abort_ncr3", MISO3, 1);
    send_cmd(8'h40, 32'h0, 8'h95, 1'b1, 8'h01);

    for (int k = 0; k < 3; k++) begin
      send_cmd(8'h77, 32'h0, 8'h65, 1'b1, 8'h01);
      send_cmd(8'h69, 32'h4000_0000, 8'h77, 1'b1, (k == 2) ? 8'h00 : 8'h01);
      push_chk("idle_after_acmd41", CARD_IDLE, (k == 2) ? 32'd0 : 32'd1);
      push_chk("idle_after_acmd41_ncr3", CARD_IDLE3, (k == 2) ? 32'd0 : 32'd1);
    end
    send_cmd(8'h51, 32'h0000_1234, 8'hFF, 1'b1, 8'h04);

    // Reset while the NCR=3 card is still sending its gap bytes.
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(8'hFF);
      exp3_q.push_back(8'hFF);
    end
    stb_q.push_back({6'd17, 32'h0000_1234});
    stb3_q.push_back({6'd17, 32'h0000_1234});
    push_chk("idle_before_rst", CARD_IDLE3, 0);
    #100 CS = 1'b0;
    xfer(8'h51); xfer(8'h00); xfer(8'h00); xfer(8'h12); xfer(8'h34); xfer(8'hFF);
    xfer(8'hFF);
    #100 RST = 1'b1;
    #1;
    push_chk("miso_in_rst_ncr3", MISO3, 1);
    push_chk("miso_in_rst", MISO, 1);
    push_chk("idle_in_rst", CARD_IDLE3, 1);
    push_chk("init_done_in_rst", INIT_DONE3, 0);
    push_chk("cmd_idx_in_rst", CMD_IDX3, 0);
    #50 RST = 1'b0;
    CS = 1'b1;
    MOSI = 1'b1;
    #2000;
    push_chk("miso_bytes_left", exp_q.size(), 0);
    push_chk("miso_bytes_left_ncr3", exp3_q.size(), 0);
    push_chk("strobes_left", stb_q.size(), 0);
    push_chk("strobes_left_ncr3", stb3_q.size(), 0);
    #200;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
